gray2bin_pipe: RTL and testbench
================================

# gray2bin_pipe

Parametrised Gray-to-binary pointer converter for FIFO address crossing and other critical-path address logic. The block takes a Gray-coded pointer from another clock domain, optionally resynchronises it through a configurable flop chain, and converts it to binary. The conversion uses a configurable number of register stages so that the WIDTH-deep XOR chain is split for timing closure. It also flags illegal multi-bit Gray transitions, and indicates when the output is valid and when it has changed. It sits on the receiving side of async FIFO pointer paths, directly feeding full/empty comparison logic.

## Interface
- WIDTH, 8, pointer width in bits (2..32)
- SYNC_STAGES, 2, synchroniser flops on addr_gray (0..3; 0 = same-domain input, no sync)
- PIPE_STAGES, 2, conversion register stages (1..4, and PIPE_STAGES <= WIDTH)
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  reset, asynchronous, active-low
- addr_gray  input  WIDTH  Gray-coded pointer, sampled every cycle
- err_clr  input  1  synchronous clear of err_sticky
- addr  output  WIDTH  binary pointer
- addr_vld  output  1  high once the pipeline holds real samples
- addr_chg  output  1  one-cycle pulse: addr differs from its previous value
- multi_bit_err  output  1  one-cycle pulse aligned with addr: sample differed from its predecessor in more than one bit
- err_sticky  output  1  latched OR of multi_bit_err

## Operation
- Sync chain: addr_gray passes through SYNC_STAGES flops to produce gray_s. When SYNC_STAGES = 0, gray_s = addr_gray (wire).
- Conversion: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i].
  - Bits are partitioned MSB-first into PIPE_STAGES segments of SEG = ceil(WIDTH/PIPE_STAGES) bits; the last segment takes the remainder.
  - Stage k computes its segment using the boundary bit registered by stage k-1, and carries the still-unconverted Gray bits and the already-converted binary bits forward.
  - The output of the final stage is addr.
- Error detect:
  - gray_prev is registered from gray_s each cycle.
  - err_raw = popcount(gray_s ^ gray_prev) > 1.
  - err_raw travels down the conversion pipeline alongside its sample, so that multi_bit_err coincides with that sample's addr.
  - Zero-bit and one-bit changes are legal.
- Fill counter: counts from 0 to LAT = SYNC_STAGES + PIPE_STAGES after reset, then saturates.
  - addr_vld = 1 when count == LAT.
  - The first sample entering the compare stage after reset is not compared, because gray_prev is invalid; its err_raw is forced to 0.
- addr_chg = addr_vld & (addr != addr_q), where addr_q is addr delayed one cycle. addr_chg is suppressed in the cycle addr_vld first rises.
- err_sticky:
  - Set when multi_bit_err = 1; held until err_clr.
  - err_clr is synchronous. When err_clr and multi_bit_err occur in the same cycle, set wins and err_sticky stays 1.
- Wrap-around: Gray 1000_0000 to 0000_0000 (bin FF to 00) is a single-bit change and is legal. addr_chg pulses on it; multi_bit_err does not.
- Arithmetic: pure XOR, no carries; every WIDTH value maps bijectively.

## Timing
- Latency addr_gray to addr is SYNC_STAGES + PIPE_STAGES cycles. multi_bit_err has the same latency. addr_chg and err_sticky lag addr by 1 cycle.
- Throughput: one sample per cycle, no stalls, no backpressure.
- Reset (async assert, held while low) drives:
  - all sync flops, pipeline registers, gray_prev and addr_q to 0
  - addr = 0, addr_vld = 0, addr_chg = 0, multi_bit_err = 0, err_sticky = 0
  - fill count = 0
- Reset mid-operation: all in-flight samples are discarded. addr_vld drops immediately and re-asserts exactly LAT cycles after the first sys_clk rising edge following deassertion. No error is reported for the first post-reset sample.
- Critical path: at most SEG XOR levels plus one flop per stage. Popcount is computed in the compare stage and must not reach the output directly.

## Test plan
- Reset release with WIDTH=8, SYNC=2, PIPE=2 and addr_gray held at 8'h00 → addr_vld rises on the 4th edge after release; addr=8'h00; no flags.
- Sequence 8'h00, 8'h01, 8'h03, 8'h02, one per cycle → addr = 8'h00, 8'h01, 8'h02, 8'h03 after 4 cycles of latency; addr_chg pulses per step; multi_bit_err stays 0.
- Step 8'h00 to 8'h80 → addr 8'hFF, then back to 8'h00 (wrap) → no multi_bit_err; addr_chg pulses on both transitions.
- Step 8'h00 to 8'h03 → multi_bit_err pulses 1 cycle aligned with addr=8'h02; err_sticky=1 on the next cycle. err_clr then clears it. A simultaneous err_clr and new error leaves err_sticky=1.
- Assert sys_rst_n low mid-sequence at 8'h5A → all outputs 0 asynchronously. After release with a constant 8'h5A input → addr=8'h6C after LAT cycles; multi_bit_err=0.
- Sweep PIPE_STAGES 1..4 and SYNC_STAGES 0..3 at WIDTH=5 and 32, running an exhaustive or random Gray count → addr matches the reference model at latency SYNC_STAGES + PIPE_STAGES, bit-exact.

Source files
------------

// File: rtl/gray2bin_pipe.sv
// gray2bin_pipe: Gray-coded pointer receiver. Optional resynchroniser, segmented
// Gray-to-binary conversion pipeline, multi-bit transition detection and
// output-valid / output-changed indication.
module gray2bin_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] addr_gray,
    input  logic             err_clr,
    output logic [WIDTH-1:0] addr,
    output logic             addr_vld,
    output logic             addr_chg,
    output logic             multi_bit_err,
    output logic             err_sticky
);

    localparam int unsigned SEG   = (WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int unsigned LAT   = SYNC_STAGES + PIPE_STAGES;
    localparam int unsigned CNT_W = $clog2(LAT + 1);
    localparam int          W_I   = int'(WIDTH);
    localparam int          SEG_I = int'(SEG);

    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

    // Segment k owns bits [seg_hi(k):seg_lo(k)], MSB first; the last one takes the remainder.
    function automatic int seg_hi(input int k);
        return W_I - 1 - k * SEG_I;
    endfunction

    function automatic int seg_lo(input int k);
        int lo;
        lo = W_I - (k + 1) * SEG_I;
        return (lo < 0) ? 0 : lo;
    endfunction

    logic [WIDTH-1:0] gray_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign gray_s = addr_gray;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        // Resynchronising flop chain for the incoming Gray pointer.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
                sync_q[0] <= addr_gray;
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end

        assign gray_s = sync_q[SYNC_STAGES-1];
    end

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] gray_prev_q;
    logic [WIDTH-1:0] gray_diff;
    logic             err_raw;

    // Compare stage: more than one bit set in the diff means x & (x-1) is non-zero.
    // Until gray_prev holds a real sample (count <= SYNC_STAGES) no error is raised.
    always_comb begin
        gray_diff = gray_s ^ gray_prev_q;
        err_raw   = (cnt_q > SYNC_CNT) && ((gray_diff & (gray_diff - W_ONE)) != '0);
    end

    // Fill counter (saturates at LAT) and previous-sample register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q       <= '0;
            gray_prev_q <= '0;
        end else begin
            gray_prev_q <= gray_s;
            if (cnt_q != LAT_CNT) cnt_q <= cnt_q + CNT_ONE;
        end
    end

    logic [WIDTH-1:0]       stage_in [PIPE_STAGES];
    logic [WIDTH-1:0]       pipe_d   [PIPE_STAGES];
    logic [WIDTH-1:0]       pipe_q   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] err_in;
    logic [PIPE_STAGES-1:0] err_q;

    // Stage inputs: stage 0 takes the compare-stage sample, later stages the previous register.
    always_comb begin
        stage_in[0] = gray_s;
        err_in[0]   = err_raw;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            stage_in[k] = pipe_q[k-1];
            err_in[k]   = err_q[k-1];
        end
    end

    // Per-stage conversion: bits above the segment are already binary, bits below still Gray;
    // the segment's top bit chains off the registered boundary bit from the previous stage.
    always_comb begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            pipe_d[k] = stage_in[k];
            for (int i = W_I - 2; i >= 0; i--) begin
                if (i >= seg_lo(k) && i <= seg_hi(k)) begin
                    pipe_d[k][i] = pipe_d[k][i+1] ^ stage_in[k][i];
                end
            end
        end
    end

    // Conversion pipeline registers; the error flag travels with its sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < PIPE_STAGES; k++) pipe_q[k] <= '0;
            err_q <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) pipe_q[k] <= pipe_d[k];
            err_q <= err_in;
        end
    end

    assign addr          = pipe_q[PIPE_STAGES-1];
    assign multi_bit_err = err_q[PIPE_STAGES-1];
    assign addr_vld      = (cnt_q == LAT_CNT);

    logic [WIDTH-1:0] addr_q;
    logic             vld_q;
    logic             chg_q;
    logic             sticky_q;

    // Change pulse (suppressed on the first valid cycle) and sticky error; set beats clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_q   <= '0;
            vld_q    <= 1'b0;
            chg_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            addr_q <= addr;
            vld_q  <= addr_vld;
            chg_q  <= addr_vld && vld_q && (addr != addr_q);
            if (multi_bit_err) begin
                sticky_q <= 1'b1;
            end else if (err_clr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign addr_chg   = chg_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Scoreboard bench for gray2bin_pipe: one 8/2/2 instance plus a sweep over
// WIDTH {5,32} x SYNC_STAGES 0..3 x PIPE_STAGES 1..4, all driven by a shared stimulus.
module tb_gray2bin_pipe;

    localparam int NCFG = 33;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] stim_gray;
    logic        err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    function automatic int cfg_w(input int c);
        if (c == 0) return 8;
        return ((c - 1) < 16) ? 5 : 32;
    endfunction

    function automatic int cfg_s(input int c);
        if (c == 0) return 2;
        return ((c - 1) % 16) / 4;
    endfunction

    function automatic int cfg_p(input int c);
        if (c == 0) return 2;
        return ((c - 1) % 4) + 1;
    endfunction

    // Reference Gray decode: binary = XOR of all right shifts of the Gray word.
    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int s = 0; s < 32; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic check(input int c, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", c, name, act, exp, $time);
        end
    endtask

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int W   = cfg_w(c);
        localparam int S   = cfg_s(c);
        localparam int P   = cfg_p(c);
        localparam int LAT = S + P;

        logic [W-1:0] addr;
        logic         addr_vld;
        logic         addr_chg;
        logic         multi_bit_err;
        logic         err_sticky;
        logic [W:0]   exp_q [$];

        gray2bin_pipe #(
            .WIDTH       (W),
            .SYNC_STAGES (S),
            .PIPE_STAGES (P)
        ) u_dut (
            .sys_clk       (sys_clk),
            .sys_rst_n     (sys_rst_n),
            .addr_gray     (stim_gray[W-1:0]),
            .err_clr       (err_clr),
            .addr          (addr),
            .addr_vld      (addr_vld),
            .addr_chg      (addr_chg),
            .multi_bit_err (multi_bit_err),
            .err_sticky    (err_sticky)
        );

        // Every sample taken at a clock edge out of reset becomes an expected {err, addr}.
        initial begin : p_push
            logic [W-1:0] cur;
            logic [W-1:0] prv;
            bit           have;
            have = 1'b0;
            prv  = '0;
            forever begin
                @(posedge sys_clk);
                if (!sys_rst_n) begin
                    exp_q.delete();
                    have = 1'b0;
                end else begin
                    cur = stim_gray[W-1:0];
                    exp_q.push_back({have && ($countones(cur ^ prv) > 1), W'(g2b(32'(cur)))});
                    prv  = cur;
                    have = 1'b1;
                end
            end
        end

        // Monitor: pops whenever the DUT should present a sample, derives chg/sticky.
        initial begin : p_mon
            int           edges;
            logic [W:0]   got;
            bit           v1, v2, e1, sticky_m;
            bit           vld_exp, chg_exp, sticky_exp, e_exp;
            logic [W-1:0] a1, a2, a_exp;
            edges = 0; v1 = 0; v2 = 0; e1 = 0; sticky_m = 0; a1 = '0; a2 = '0;
            forever begin
                @(posedge sys_clk);
                #1;
                if (!sys_rst_n) begin
                    edges = 0; v1 = 0; v2 = 0; e1 = 0; sticky_m = 0; a1 = '0; a2 = '0;
                    check(c, "held_rst_outs",
                          64'({addr, addr_vld, addr_chg, multi_bit_err, err_sticky}), 64'd0);
                end else begin
                    if (edges < LAT) edges++;
                    vld_exp    = (edges >= LAT);
                    chg_exp    = v1 && v2 && (a1 != a2);
                    sticky_exp = e1 ? 1'b1 : (err_clr ? 1'b0 : sticky_m);
                    a_exp      = '0;
                    e_exp      = 1'b0;
                    if (vld_exp) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL cfg%0d queue_empty: got 0 entries expected >0", c);
                        end else begin
                            got   = exp_q.pop_front();
                            a_exp = got[W-1:0];
                            e_exp = got[W];
                        end
                        check(c, "addr", 64'(addr), 64'(a_exp));
                    end
                    check(c, "addr_vld", 64'(addr_vld), 64'(vld_exp));
                    check(c, "multi_bit_err", 64'(multi_bit_err), 64'(e_exp));
                    check(c, "addr_chg", 64'(addr_chg), 64'(chg_exp));
                    check(c, "err_sticky", 64'(err_sticky), 64'(sticky_exp));
                    v2 = v1; a2 = a1;
                    v1 = vld_exp; a1 = a_exp; e1 = e_exp; sticky_m = sticky_exp;
                end
            end
        end

        // Outputs must clear as soon as reset asserts, without waiting for a clock.
        initial begin : p_async
            forever begin
                @(negedge sys_rst_n);
                #1;
                check(c, "async_rst_outs",
                      64'({addr, addr_vld, addr_chg, multi_bit_err, err_sticky}), 64'd0);
            end
        end
    end

    task automatic step(input logic [31:0] g, input logic clr);
        @(negedge sys_clk);
        stim_gray = g;
        err_clr   = clr;
    endtask

    initial begin
        logic [31:0] n;
        int          r;
        stim_gray = '0;
        err_clr   = 1'b0;
        sys_rst_n = 1'b1;
        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Reset release with constant zero input.
        repeat (6) step(32'h00, 1'b0);

        // Short Gray count.
        step(32'h01, 1'b0);
        step(32'h03, 1'b0);
        step(32'h02, 1'b0);
        repeat (6) step(32'h02, 1'b0);

        // Wrap-around steps 00 -> 80 -> 00.
        repeat (6) step(32'h00, 1'b0);
        repeat (6) step(32'h80, 1'b0);
        repeat (6) step(32'h00, 1'b0);

        // Two-bit jump, then clear the sticky flag.
        repeat (6) step(32'h03, 1'b0);
        step(32'h03, 1'b1);
        repeat (3) step(32'h03, 1'b0);

        // Two-bit jump back, with err_clr landing on the same edge as the error (LAT=4).
        repeat (4) step(32'h00, 1'b0);
        step(32'h00, 1'b1);
        @(posedge sys_clk);
        #1;
        check(0, "sticky_set_wins", 64'(g_cfg[0].err_sticky), 64'd1);
        repeat (3) step(32'h00, 1'b0);
        step(32'h00, 1'b1);
        repeat (3) step(32'h00, 1'b0);

        // Reset mid-sequence with 5A held; 5A decodes to 6C.
        repeat (4) step(32'h5A, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check(0, "vld_before_lat", 64'(g_cfg[0].addr_vld), 64'd0);
        @(posedge sys_clk);
        #1;
        check(0, "addr_after_rst", 64'(g_cfg[0].addr), 64'h6C);
        check(0, "vld_after_rst", 64'(g_cfg[0].addr_vld), 64'd1);
        repeat (4) step(32'h5A, 1'b0);

        // Random Gray count with occasional jumps, holds, clears and one reset.
        n = 32'h0000_006C;
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 15);
            if (r == 0) n = $urandom;
            else if (r < 12) n = n + 32'd1;
            if (it == 1500) begin
                @(negedge sys_clk);
                sys_rst_n = 1'b0;
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
            end
            step(n ^ (n >> 1), ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end
        repeat (12) step(n ^ (n >> 1), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
